stall_ctrl: RTL and testbench

Pipeline stall controller for the five-stage core. It merges three stall sources into the `StallBus` vector that every pipeline register consumes:

- load-use hazards, detected here from ID operands and the EX load destination;
- the multi-cycle divider, sequenced here by a counter FSM;
- data-SRAM wait from MEM.

It sits beside the pipeline, fed by ID/EX/MEM side signals, and drives `stall` to PC, IF, ID, EX, MEM and WB.

---
 rtl/stall_ctrl.sv | 152 +++++++++++++++
 tb/tb_stall_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl
// Purpose  : Pipeline stall controller for the five-stage core. Merges
//            load-use hazards, the multi-cycle divider sequence and data-SRAM
//            wait into one per-stage stall vector, and counts stall cycles.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous reset, active-low (0 = reset)
//   id_valid     in   ID holds a real instruction
//   id_rs/id_rt  in   ID source registers
//   id_rs_used   in   ID instruction reads rs
//   id_rt_used   in   ID instruction reads rt
//   ex_load      in   EX holds a load
//   ex_rf_waddr  in   EX destination register
//   ex_div       in   EX holds div/divu (level while it sits in EX)
//   mem_wait     in   data SRAM not ready, MEM must hold
//   stall        out  per-stage stop: bit0 PC .. bit5 WB
//   div_busy     out  divider in RUN
//   div_done     out  divider result valid in EX this cycle
//   stall_cycles out  saturating count of cycles with stall[0]=1
// ============================================================================
module stall_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int STALL_W    = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_rs_used,
  input  logic               id_rt_used,
  input  logic               ex_load,
  input  logic [4:0]         ex_rf_waddr,
  input  logic               ex_div,
  input  logic               mem_wait,
  output logic [STALL_W-1:0] stall,
  output logic               div_busy,
  output logic               div_done,
  output logic [31:0]        stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 1);

  // Stall patterns: each freezes a prefix of the pipeline and bubbles the
  // stage just after it.
  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_DIV  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LU   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_NONE = '0;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        div_busy_q, div_busy_d;
  logic        div_done_q, div_done_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic        load_use;

  // Load-use hazard: register 0 is never a real dependency.
  always_comb begin
    load_use = id_valid && ex_load && (ex_rf_waddr != 5'd0) &&
               ((id_rs_used && (id_rs == ex_rf_waddr)) ||
                (id_rt_used && (id_rt == ex_rf_waddr)));
  end

  // Divider sequencer. RUN ignores mem_wait so the division keeps progressing
  // while MEM is held; only DONE waits for MEM because EX cannot advance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ex_div) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
        end
      end
      S_RUN: begin
        if (cnt_q == 6'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_DONE: begin
        if (!mem_wait) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
    // Status outputs are registered, so they are derived from the next state.
    div_busy_d = (state_d == S_RUN);
    div_done_d = (state_d == S_DONE);
  end

  // Stall vector is combinational so hazards and SRAM wait take effect in the
  // same cycle. Reset low forces it clear even between clock edges.
  always_comb begin
    stall = STALL_NONE;
    if (rst) begin
      if (mem_wait) begin
        stall = STALL_MEM;
      end else if (state_q == S_RUN) begin
        stall = STALL_DIV;
      end else if (load_use) begin
        stall = STALL_LU;
      end
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 6'd0;
      div_busy_q     <= 1'b0;
      div_done_q     <= 1'b0;
      stall_cycles_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_busy_q     <= div_busy_d;
      div_done_q     <= div_done_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign div_busy     = div_busy_q;
  assign div_done     = div_done_q;
  assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stall_ctrl
// Purpose  : Directed self-checking bench for stall_ctrl (DIV_CYCLES=4).
//            Inputs change 1ns after the rising edge; outputs are sampled on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stall_ctrl;

  localparam int DIV_CYCLES = 4;
  localparam int STALL_W    = 6;

  logic               clk;
  logic               rst;
  logic               id_valid;
  logic [4:0]         id_rs;
  logic [4:0]         id_rt;
  logic               id_rs_used;
  logic               id_rt_used;
  logic               ex_load;
  logic [4:0]         ex_rf_waddr;
  logic               ex_div;
  logic               mem_wait;
  logic [STALL_W-1:0] stall;
  logic               div_busy;
  logic               div_done;
  logic [31:0]        stall_cycles;

  int checks   = 0;
  int failures = 0;

  stall_ctrl #(
    .DIV_CYCLES(DIV_CYCLES),
    .STALL_W   (STALL_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .ex_load     (ex_load),
    .ex_rf_waddr (ex_rf_waddr),
    .ex_div      (ex_div),
    .mem_wait    (mem_wait),
    .stall       (stall),
    .div_busy    (div_busy),
    .div_done    (div_done),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next cycle: inputs may be driven right after this returns.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid    = 1'b0;
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_rs_used  = 1'b0;
    id_rt_used  = 1'b0;
    ex_load     = 1'b0;
    ex_rf_waddr = 5'd0;
    ex_div      = 1'b0;
    mem_wait    = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    #12;
    checks++;
    if (stall !== 6'b000000 || div_busy !== 1'b0 || div_done !== 1'b0 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: stall=%b busy=%b done=%b cnt=%0d, required 000000/0/0/0",
               stall, div_busy, div_done, stall_cycles);
    end
    // Reset must also mask a live SRAM wait.
    mem_wait = 1'b1;
    #1;
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL reset_masks_stall: stall=%b required 000000", stall);
    end
    mem_wait = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    // Hazard on rs: one-cycle stall, then the load leaves EX.
    id_valid = 1'b1; id_rs = 5'd5; id_rs_used = 1'b1;
    ex_load = 1'b1; ex_rf_waddr = 5'd5;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111) begin
      failures++;
      $display("FAIL load_use_rs: stall=%b required 000111", stall);
    end
    next_cycle();
    ex_load = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_one_cycle: stall=%b required 000000", stall);
    end
    // Destination r0 is never a hazard.
    next_cycle();
    ex_load = 1'b1; ex_rf_waddr = 5'd0; id_rs = 5'd0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_r0: stall=%b required 000000", stall);
    end
    // Hazard on rt with rs unused.
    next_cycle();
    ex_rf_waddr = 5'd9; id_rs = 5'd9; id_rs_used = 1'b0; id_rt = 5'd9; id_rt_used = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111) begin
      failures++;
      $display("FAIL load_use_rt: stall=%b required 000111", stall);
    end
    // Matching register but not read -> no hazard.
    next_cycle();
    id_rt_used = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_unused: stall=%b required 000000", stall);
    end
    // Bubble in ID -> no hazard.
    next_cycle();
    id_rt_used = 1'b1; id_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000) begin
      failures++;
      $display("FAIL load_use_bubble: stall=%b required 000000", stall);
    end
    clear_inputs();
  endtask

  task automatic test_divide();
    do_reset();
    ex_div = 1'b1;                       // cycle T
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || div_busy !== 1'b0) begin
      failures++;
      $display("FAIL div_cycle_T: stall=%b busy=%b required 000000/0", stall, div_busy);
    end
    for (int k = 1; k <= DIV_CYCLES; k++) begin   // cycles T+1..T+4
      next_cycle();
      @(negedge clk);
      checks++;
      if (stall !== 6'b001111 || div_busy !== 1'b1 || div_done !== 1'b0) begin
        failures++;
        $display("FAIL div_run_T+%0d: stall=%b busy=%b done=%b required 001111/1/0",
                 k, stall, div_busy, div_done);
      end
    end
    next_cycle();                        // T+5 DONE
    @(negedge clk);
    checks++;
    if (stall !== 6'b000000 || div_busy !== 1'b0 || div_done !== 1'b1) begin
      failures++;
      $display("FAIL div_done: stall=%b busy=%b done=%b required 000000/0/1",
               stall, div_busy, div_done);
    end
    next_cycle();                        // T+6 IDLE, div has left EX
    ex_div = 1'b0;
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b0 || div_done !== 1'b0 || stall !== 6'b000000) begin
      failures++;
      $display("FAIL div_idle: busy=%b done=%b stall=%b required 0/0/000000",
               div_busy, div_done, stall);
    end
    // 4 RUN cycles stalled the PC.
    checks++;
    if (stall_cycles !== 32'd4) begin
      failures++;
      $display("FAIL div_stall_count: got %0d required 4", stall_cycles);
    end
  endtask

  task automatic test_mem_wait_run();
    logic [5:0] exp_stall [0:8];
    logic       exp_busy  [0:8];
    logic       exp_done  [0:8];
    logic       mw        [0:8];
    exp_stall = '{6'b000000, 6'b001111, 6'b011111, 6'b011111, 6'b011111,
                  6'b011111, 6'b011111, 6'b000000, 6'b000000};
    exp_busy  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    mw        = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int k = 0; k <= 8; k++) begin   // cycles T..T+8
      if (k > 0) next_cycle();
      mem_wait = mw[k];
      ex_div   = (k <= 7);
      @(negedge clk);
      checks++;
      if (stall !== exp_stall[k] || div_busy !== exp_busy[k] || div_done !== exp_done[k]) begin
        failures++;
        $display("FAIL memwait_run_T+%0d: stall=%b busy=%b done=%b required %b/%b/%b",
                 k, stall, div_busy, div_done, exp_stall[k], exp_busy[k], exp_done[k]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    id_valid = 1'b1; id_rt = 5'd7; id_rt_used = 1'b1;
    ex_load = 1'b1; ex_rf_waddr = 5'd7; mem_wait = 1'b1;
    @(negedge clk);
    checks++;
    if (stall !== 6'b011111) begin
      failures++;
      $display("FAIL prio_memwait_over_lu: stall=%b required 011111", stall);
    end
    next_cycle();
    mem_wait = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 6'b000111) begin
      failures++;
      $display("FAIL prio_lu_after_memwait: stall=%b required 000111", stall);
    end
    // Divider RUN covers a simultaneous load-use.
    next_cycle();
    ex_div = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall !== 6'b001111) begin
      failures++;
      $display("FAIL prio_run_over_lu: stall=%b required 001111", stall);
    end
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_div = 1'b1;                       // T
    next_cycle();                        // T+1
    next_cycle();                        // T+2
    @(negedge clk);
    checks++;
    if (div_busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre_busy: busy=%b required 1", div_busy);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (div_busy !== 1'b0 || stall !== 6'b000000 || div_done !== 1'b0 || stall_cycles !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate: busy=%b stall=%b done=%b cnt=%0d required 0/000000/0/0",
               div_busy, stall, div_done, stall_cycles);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    ex_div = 1'b0;
    for (int k = 0; k < DIV_CYCLES + 2; k++) begin
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b0 || div_done !== 1'b0 || stall !== 6'b000000) begin
        failures++;
        $display("FAIL areset_stays_idle_%0d: busy=%b done=%b stall=%b required 0/0/000000",
                 k, div_busy, div_done, stall);
      end
      next_cycle();
    end
  endtask

  task automatic test_counter();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      mem_wait = 1'b1;
    end
    next_cycle();
    mem_wait = 1'b0;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'd10) begin
      failures++;
      $display("FAIL counter_ten: got %0d required 10", stall_cycles);
    end
    // Preload near the top and check saturation.
    @(negedge clk);
    force dut.stall_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cycles_q;
    next_cycle();
    mem_wait = 1'b1;
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL counter_preload: got %h required fffffffe", stall_cycles);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL counter_reach_max: got %h required ffffffff", stall_cycles);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cycles !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL counter_saturate: got %h required ffffffff", stall_cycles);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_divide();
    test_mem_wait_run();
    test_priority();
    test_async_reset();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
